// File: rtl/tri_raster_ctrl.sv
// Triangle rasterisation sequencer: accepts a triangle, scans its screen-clipped bounding box
// row-major and streams inside pixels. Define TRI_EARLY_EXIT_EN to stop edge tests on the first miss.
module tri_raster_ctrl #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] p1x,
    input  logic [COORD_W-1:0] p1y,
    input  logic [COORD_W-1:0] p2x,
    input  logic [COORD_W-1:0] p2y,
    input  logic [COORD_W-1:0] p3x,
    input  logic [COORD_W-1:0] p3y,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               busy,
    output logic               done
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * DW;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] ZERO   = {COORD_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BBOX   = 3'd1,
        ORIENT = 3'd2,
        EVAL   = 3'd3,
        EMIT   = 3'd4,
        STEP   = 3'd5,
        FIN    = 3'd6
    } state_t;

    function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] d);
        return $signed({{DW{d[DW-1]}}, d});
    endfunction

    // True when (a-q) x (b-q) is strictly positive in the orientation sense used by the inside rule.
    function automatic logic edge_sign(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                       input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                                       input logic [COORD_W-1:0] qx, input logic [COORD_W-1:0] qy);
        logic signed [DW-1:0] d_ax;
        logic signed [DW-1:0] d_by;
        logic signed [DW-1:0] d_bx;
        logic signed [DW-1:0] d_ay;
        logic signed [PW-1:0] lhs;
        logic signed [PW-1:0] rhs;
        d_ax = $signed({1'b0, ax}) - $signed({1'b0, qx});
        d_by = $signed({1'b0, by}) - $signed({1'b0, qy});
        d_bx = $signed({1'b0, bx}) - $signed({1'b0, qx});
        d_ay = $signed({1'b0, ay}) - $signed({1'b0, qy});
        lhs  = sext(d_ax) * sext(d_by);
        rhs  = sext(d_bx) * sext(d_ay);
        return (lhs > rhs);
    endfunction

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    state_t             state_r;
    state_t             state_s;
    state_t             fsm_next_s;

    logic [COORD_W-1:0] v1x_r, v1y_r, v2x_r, v2y_r, v3x_r, v3y_r;
    logic [COORD_W-1:0] xmin_r, xmax_r, ymax_r;
    logic [COORD_W-1:0] cx_r, cy_r;
    logic [1:0]         k_r;
    logic               t_r;
    logic               inside_r;

    logic [COORD_W-1:0] bb_xmin_s, bb_ymin_s, bb_xmax_s, bb_ymax_s;
    logic               bb_empty_s;
    logic               row_end_s;
    logic               last_pix_s;

    logic [COORD_W-1:0] op_ax_s, op_ay_s, op_bx_s, op_by_s, op_qx_s, op_qy_s;
    logic               edge_s;
    logic               match_s;

    logic               tri_ready_r;
    logic               pix_valid_r;
    logic [COORD_W-1:0] pix_x_r;
    logic [COORD_W-1:0] pix_y_r;
    logic               busy_r;
    logic               done_r;

    // Bounding box of the latched vertices; only the upper bounds need clipping since coordinates are unsigned.
    always_comb begin
        bb_xmin_s  = min3(v1x_r, v2x_r, v3x_r);
        bb_ymin_s  = min3(v1y_r, v2y_r, v3y_r);
        bb_xmax_s  = max3(v1x_r, v2x_r, v3x_r);
        bb_ymax_s  = max3(v1y_r, v2y_r, v3y_r);
        bb_xmax_s  = (bb_xmax_s > X_LAST) ? X_LAST : bb_xmax_s;
        bb_ymax_s  = (bb_ymax_s > Y_LAST) ? Y_LAST : bb_ymax_s;
        bb_empty_s = (bb_xmin_s > X_LAST) || (bb_ymin_s > Y_LAST);
        row_end_s  = (cx_r == xmax_r);
        last_pix_s = row_end_s && (cy_r == ymax_r);
    end

    // Operand mux in front of the single edge-sign unit: orientation in ORIENT, edge k_r otherwise.
    always_comb begin
        op_ax_s = v1x_r;
        op_ay_s = v1y_r;
        op_bx_s = v2x_r;
        op_by_s = v2y_r;
        op_qx_s = cx_r;
        op_qy_s = cy_r;
        case (state_r)
            ORIENT: begin
                op_qx_s = v3x_r;
                op_qy_s = v3y_r;
            end
            default: begin
                case (k_r)
                    2'd0: begin
                        op_ax_s = v1x_r;
                        op_ay_s = v1y_r;
                        op_bx_s = v2x_r;
                        op_by_s = v2y_r;
                    end
                    2'd1: begin
                        op_ax_s = v2x_r;
                        op_ay_s = v2y_r;
                        op_bx_s = v3x_r;
                        op_by_s = v3y_r;
                    end
                    default: begin
                        op_ax_s = v3x_r;
                        op_ay_s = v3y_r;
                        op_bx_s = v1x_r;
                        op_by_s = v1y_r;
                    end
                endcase
            end
        endcase
        edge_s  = edge_sign(op_ax_s, op_ay_s, op_bx_s, op_by_s, op_qx_s, op_qy_s);
        match_s = (edge_s == t_r);
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (tri_valid) fsm_next_s = BBOX;
                else           fsm_next_s = IDLE;
            end
            BBOX: begin
                if (bb_empty_s) fsm_next_s = FIN;
                else            fsm_next_s = ORIENT;
            end
            ORIENT: fsm_next_s = EVAL;
            EVAL: begin
                if (k_r == 2'd2) begin
                    if (inside_r && match_s) fsm_next_s = EMIT;
                    else                     fsm_next_s = STEP;
                end else begin
`ifdef TRI_EARLY_EXIT_EN
                    if (match_s) fsm_next_s = EVAL;
                    else         fsm_next_s = STEP;
`else
                    fsm_next_s = EVAL;
`endif
                end
            end
            EMIT: begin
                if (pix_ready) fsm_next_s = STEP;
                else           fsm_next_s = EMIT;
            end
            STEP: begin
                if (last_pix_s) fsm_next_s = FIN;
                else            fsm_next_s = EVAL;
            end
            FIN:     fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
        state_s = (abort && (state_r != IDLE)) ? IDLE : fsm_next_s;
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Vertex latch, box registers and scan position.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            v1x_r    <= ZERO;
            v1y_r    <= ZERO;
            v2x_r    <= ZERO;
            v2y_r    <= ZERO;
            v3x_r    <= ZERO;
            v3y_r    <= ZERO;
            xmin_r   <= ZERO;
            xmax_r   <= ZERO;
            ymax_r   <= ZERO;
            cx_r     <= ZERO;
            cy_r     <= ZERO;
            k_r      <= 2'd0;
            t_r      <= 1'b0;
            inside_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tri_valid) begin
                        v1x_r <= p1x;
                        v1y_r <= p1y;
                        v2x_r <= p2x;
                        v2y_r <= p2y;
                        v3x_r <= p3x;
                        v3y_r <= p3y;
                    end
                end
                BBOX: begin
                    xmin_r <= bb_xmin_s;
                    xmax_r <= bb_xmax_s;
                    ymax_r <= bb_ymax_s;
                    cx_r   <= bb_xmin_s;
                    cy_r   <= bb_ymin_s;
                end
                ORIENT: begin
                    t_r <= edge_s;
                    k_r <= 2'd0;
                end
                EVAL: begin
                    inside_r <= (k_r == 2'd0) ? match_s : (inside_r & match_s);
                    k_r      <= k_r + 2'd1;
                end
                STEP: begin
                    k_r <= 2'd0;
                    if (row_end_s) begin
                        cx_r <= xmin_r;
                        if (!last_pix_s) cy_r <= cy_r + ONE;
                    end else begin
                        cx_r <= cx_r + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake/status outputs; pixel coordinates are captured once on entry to EMIT.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tri_ready_r <= 1'b1;
            pix_valid_r <= 1'b0;
            pix_x_r     <= ZERO;
            pix_y_r     <= ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            tri_ready_r <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            pix_valid_r <= (state_s == EMIT);
            done_r      <= (state_r == FIN) && !abort;
            if ((state_s == EMIT) && (state_r != EMIT)) begin
                pix_x_r <= cx_r;
                pix_y_r <= cy_r;
            end
        end
    end

    assign tri_ready = tri_ready_r;
    assign pix_valid = pix_valid_r;
    assign pix_x     = pix_x_r;
    assign pix_y     = pix_y_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Scoreboard bench for tri_raster_ctrl: stimulus pushes expected pixels and done latencies,
// a negedge monitor pops and compares them.
module tb_tri_raster_ctrl;

    localparam int CW = 11;

`ifdef TRI_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int stall;
    } pix_t;

    typedef struct {
        int lo;
        int hi;
    } lat_t;

    logic          CLOCK_50;
    logic          reset;
    logic          tri_valid;
    logic          tri_ready;
    logic [CW-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic          abort;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_x, pix_y;
    logic          busy;
    logic          done;

    pix_t sb_pix[$];
    lat_t sb_done[$];

    int n_cmp;
    int n_bad;
    int cyc;
    int acc_cyc;
    int done_cnt;
    int hs_cnt;
    int idle_req;
    int final_req;
    int stall_arm;
    int stall_x;
    int stall_y;
    int stall_len;

    tri_raster_ctrl #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tri_valid(tri_valid),
        .tri_ready(tri_ready),
        .p1x      (p1x),
        .p1y      (p1y),
        .p2x      (p2x),
        .p2y      (p2y),
        .p3x      (p3x),
        .p3y      (p3y),
        .abort    (abort),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string msg);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s", msg);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin : monitor
        pix_t          e;
        lat_t          l;
        int            lat;
        int            stall_cnt;
        int            idle_seen;
        logic          prev_valid, prev_ready, prev_done;
        logic [CW-1:0] prev_x, prev_y;
        stall_cnt  = 0;
        idle_seen  = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_done  = 1'b0;
        prev_x     = '0;
        prev_y     = '0;
        @(negedge CLOCK_50);
        chk(tri_ready == 1'b1, $sformatf("rst_tri_ready got %b want 1", tri_ready));
        chk(pix_valid == 1'b0, $sformatf("rst_pix_valid got %b want 0", pix_valid));
        chk(pix_x == 11'd0, $sformatf("rst_pix_x got %0d want 0", pix_x));
        chk(pix_y == 11'd0, $sformatf("rst_pix_y got %0d want 0", pix_y));
        chk(busy == 1'b0, $sformatf("rst_busy got %b want 0", busy));
        chk(done == 1'b0, $sformatf("rst_done got %b want 0", done));
        forever begin
            @(negedge CLOCK_50);
            if (final_req != 0) begin
                chk(sb_pix.size() == 0, $sformatf("pixels_left got %0d want 0", sb_pix.size()));
                chk(sb_done.size() == 0, $sformatf("dones_left got %0d want 0", sb_done.size()));
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (!reset) begin
                if (idle_req != idle_seen) begin
                    idle_seen = idle_req;
                    chk(tri_ready == 1'b1, $sformatf("idle_tri_ready got %b want 1", tri_ready));
                    chk(busy == 1'b0, $sformatf("idle_busy got %b want 0", busy));
                    chk(pix_valid == 1'b0, $sformatf("idle_pix_valid got %b want 0", pix_valid));
                    chk(done == 1'b0, $sformatf("idle_done got %b want 0", done));
                end
                if (prev_valid && !prev_ready) begin
                    chk(pix_valid && pix_x == prev_x && pix_y == prev_y,
                        $sformatf("stall_hold got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                                  pix_valid, pix_x, pix_y, prev_x, prev_y));
                end
                if (prev_done) chk(done == 1'b0, $sformatf("done_width got %b want 0", done));
                if (done) begin
                    done_cnt++;
                    chk(sb_done.size() != 0, "done_expected got unexpected done pulse want none");
                    if (sb_done.size() != 0) begin
                        l   = sb_done.pop_front();
                        lat = cyc - acc_cyc;
                        chk(lat >= l.lo && lat <= l.hi,
                            $sformatf("done_latency got %0d want %0d..%0d", lat, l.lo, l.hi));
                    end
                end
                if (pix_valid) begin
                    if (pix_ready) begin
                        hs_cnt++;
                        chk(sb_pix.size() != 0,
                            $sformatf("pixel_expected got (%0d,%0d) want none", pix_x, pix_y));
                        if (sb_pix.size() != 0) begin
                            e = sb_pix.pop_front();
                            chk(pix_x == 11'(e.x) && pix_y == 11'(e.y),
                                $sformatf("pixel got (%0d,%0d) want (%0d,%0d)", pix_x, pix_y, e.x, e.y));
                            chk(stall_cnt == e.stall,
                                $sformatf("stall_cycles got %0d want %0d", stall_cnt, e.stall));
                        end
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
                prev_valid = pix_valid;
                prev_ready = pix_ready;
                prev_done  = done;
                prev_x     = pix_x;
                prev_y     = pix_y;
            end else begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                prev_done  = 1'b0;
                stall_cnt  = 0;
            end
        end
    end

    // Downstream model: ready except for a programmed stall at one pixel.
    initial begin : ready_drv
        int left;
        int arm_seen;
        left      = 0;
        arm_seen  = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (stall_arm != arm_seen) begin
                arm_seen = stall_arm;
                left     = stall_len;
            end
            if (pix_valid && pix_x == 11'(stall_x) && pix_y == 11'(stall_y) && left > 0) begin
                pix_ready = 1'b0;
                left--;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    task automatic push_pix(input int x, input int y, input int stall);
        pix_t p;
        p.x = x;
        p.y = y;
        p.stall = stall;
        sb_pix.push_back(p);
    endtask

    task automatic push_lat(input int exact, input bit strict_ee);
        lat_t l;
        if (EE) begin
            l.lo = 1;
            l.hi = strict_ee ? exact - 1 : exact;
        end else begin
            l.lo = exact;
            l.hi = exact;
        end
        sb_done.push_back(l);
    endtask

    task automatic push_t1(input int stall21);
        push_pix(1, 1, 0);
        push_pix(2, 1, stall21);
        push_pix(1, 2, 0);
    endtask

    task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                            input int qx, input int qy);
        bit ok;
        ok = 1'b0;
        p1x = 11'(ax);
        p1y = 11'(ay);
        p2x = 11'(bx);
        p2y = 11'(by);
        p3x = 11'(qx);
        p3y = 11'(qy);
        tri_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            if (tri_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL accept_timeout got tri_ready=0 want 1 within 50 cycles");
            $fatal(1, "accept timeout");
        end
        @(posedge CLOCK_50);
        #1;
        acc_cyc   = cyc;
        tri_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int start;
        start = done_cnt;
        for (int i = 0; i < limit; i++) begin
            @(posedge CLOCK_50);
            if (done_cnt != start) break;
        end
        if (done_cnt == start) begin
            $display("FAIL done_timeout got no done want one within %0d cycles", limit);
            $fatal(1, "done timeout");
        end
        #1;
    endtask

    task automatic wait_hs(input int n, input int limit);
        int start;
        start = hs_cnt;
        for (int i = 0; i < limit; i++) begin
            @(posedge CLOCK_50);
            if (hs_cnt >= start + n) break;
        end
        if (hs_cnt < start + n) begin
            $display("FAIL handshake_timeout got %0d want %0d transfers", hs_cnt - start, n);
            $fatal(1, "handshake timeout");
        end
        #1;
    endtask

    initial begin : stimulus
        reset     = 1'b1;
        tri_valid = 1'b0;
        abort     = 1'b0;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        // Clockwise-positive triangle: strict interior only.
        push_t1(0);
        push_lat(106, 1'b1);
        send_tri(0, 0, 4, 0, 0, 4);
        wait_done(400);

        // Reversed winding: boundary pixels included.
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4 - y; x++)
                push_pix(x, y, 0);
        push_lat(118, 1'b0);
        send_tri(0, 0, 0, 4, 4, 0);
        wait_done(400);

        // Backpressure: five stall cycles on (2,1).
        stall_x   = 2;
        stall_y   = 1;
        stall_len = 5;
        stall_arm = stall_arm + 1;
        push_t1(5);
        push_lat(111, 1'b0);
        send_tri(0, 0, 4, 0, 0, 4);
        wait_done(400);

        // Box clipped at the lower-right screen corner.
        for (int y = 471; y <= 479; y++)
            for (int x = 631; x <= 639; x++)
                push_pix(x, y, 0);
        push_lat(484, 1'b0);
        send_tri(630, 470, 700, 470, 630, 900);
        wait_done(1000);

        // Entirely off-screen: no pixels, quick done.
        begin
            lat_t l;
            l.lo = 2;
            l.hi = 3;
            sb_done.push_back(l);
        end
        send_tri(700, 10, 800, 10, 700, 100);
        wait_done(20);

        // Abort mid-scan, before any inside pixel.
        send_tri(0, 0, 4, 0, 0, 4);
        repeat (10) @(posedge CLOCK_50);
        #1;
        abort = 1'b1;
        @(posedge CLOCK_50);
        #1;
        abort = 1'b0;
        idle_req = idle_req + 1;
        repeat (8) @(posedge CLOCK_50);
        #1;
        push_t1(0);
        push_lat(106, 1'b1);
        send_tri(0, 0, 4, 0, 0, 4);
        wait_done(400);

        // Reset right after the second pixel transfers.
        push_pix(1, 1, 0);
        push_pix(2, 1, 0);
        send_tri(0, 0, 4, 0, 0, 4);
        wait_hs(2, 200);
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        idle_req = idle_req + 1;
        repeat (8) @(posedge CLOCK_50);
        #1;
        push_t1(0);
        push_lat(106, 1'b1);
        send_tri(0, 0, 4, 0, 0, 4);
        wait_done(400);

        repeat (5) @(posedge CLOCK_50);
        #1;
        final_req = 1;
    end

endmodule
